map_column_feeder: RTL and testbench

MAP_COLUMN_FEEDER -- requirements
Module: map_column_feeder

---
 rtl/josh_map_pkg.sv | 42 ++++
 rtl/map_rom.sv | 16 +
 rtl/map_column_feeder.sv | 119 +++++++++++
 tb/tb_map_column_feeder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/josh_map_pkg.sv
// Shared constants, descriptor layout and FSM states for the map column feeder.
package josh_map_pkg;

   localparam int COL_H     = 100;
   localparam int MAP_DEPTH = 256;
   localparam int MAP_AW    = 8;
   localparam int DESC_W    = 24;

   localparam int CEIL_LSB  = 0;
   localparam int CEIL_W    = 7;
   localparam int FLOOR_LSB = 7;
   localparam int FLOOR_W   = 7;
   localparam int RUN_LSB   = 14;
   localparam int RUN_W     = 8;
   localparam int LAST_BIT  = 22;
   localparam int SPARE_BIT = 23;

   typedef struct packed {
      logic               spare;
      logic               last;
      logic [RUN_W-1:0]   run;
      logic [FLOOR_W-1:0] floor_h;
      logic [CEIL_W-1:0]  ceil_h;
   } desc_t;

   typedef enum logic [2:0] {IDLE, FETCH, EXPAND, HOLD, DONE} state_e;

   // Heights above COL_H saturate, so overlapping ceiling/floor give a solid column.
   function automatic logic [COL_H-1:0] expand_col(input logic [CEIL_W-1:0]  ceil_h,
                                                   input logic [FLOOR_W-1:0] floor_h);
      logic [COL_H-1:0] col;
      int c;
      int f;
      col = '0;
      c = (int'(ceil_h) > COL_H) ? COL_H : int'(ceil_h);
      f = (int'(floor_h) > COL_H) ? COL_H : int'(floor_h);
      for (int j = 0; j < COL_H; j++)
         col[j] = (j < c) || (j >= COL_H - f);
      return col;
   endfunction

endpackage

// File: rtl/map_rom.sv
// Descriptor ROM, one registered read cycle. The map image is written into mem
// by the memory-file loader at build time; it powers up as all-zero descriptors.
module map_rom
   import josh_map_pkg::*;
(
   input  logic              clk,
   input  logic [MAP_AW-1:0] addr_i,
   output logic [DESC_W-1:0] data_o
);

   logic [DESC_W-1:0] mem [MAP_DEPTH] = '{default: '0};

   always_ff @(posedge clk)
      data_o <= mem[addr_i];

endmodule

// File: rtl/map_column_feeder.sv
// Streams wall columns expanded from run-length map descriptors to the game datapath.
// MAP_LOOP_EN: wrap to descriptor 0 after the last one instead of stopping in DONE.
module map_column_feeder
   import josh_map_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             col_ready,
   output logic             col_valid,
   output logic [COL_H-1:0] col_data,
   output logic [15:0]      col_count,
   output logic             level_done,
   output logic             busy
);

   state_e            state_q;
   logic [MAP_AW-1:0] addr_q;
   logic [RUN_W-1:0]  run_q;
   logic              last_q;
   logic              valid_q;
   logic              done_q;
   logic [COL_H-1:0]  data_q;
   logic [15:0]       count_q;
   logic [DESC_W-1:0] rom_data;
   desc_t             desc;
   logic              desc_last;
   logic              hs;
   logic              unused_spare;

   map_rom u_rom (
      .clk    (clk),
      .addr_i (addr_q),
      .data_o (rom_data)
   );

   assign desc         = desc_t'(rom_data);
   assign desc_last    = desc.last || (&addr_q);
   assign hs           = valid_q && col_ready;
   assign unused_spare = desc.spare;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         run_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
`ifdef MAP_LOOP_EN
         done_q <= 1'b0;
`endif
         case (state_q)
            IDLE, DONE: if (start) begin
               state_q <= FETCH;
               addr_q  <= '0;
               count_q <= '0;
               done_q  <= 1'b0;
            end
            FETCH: state_q <= EXPAND;
            EXPAND: begin
               if (desc.run == '0) begin
                  if (desc_last) begin
`ifdef MAP_LOOP_EN
                     addr_q  <= '0;
                     state_q <= FETCH;
`else
                     state_q <= DONE;
`endif
                     done_q  <= 1'b1;
                  end else begin
                     addr_q  <= addr_q + 1'b1;
                     state_q <= FETCH;
                  end
               end else begin
                  run_q   <= desc.run;
                  last_q  <= desc_last;
                  data_q  <= expand_col(desc.ceil_h, desc.floor_h);
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end
            end
            HOLD: if (hs) begin
               if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
               // Repeat the held column back-to-back until the run is spent.
               if (run_q > 8'd1) begin
                  run_q <= run_q - 1'b1;
               end else begin
                  run_q   <= '0;
                  valid_q <= 1'b0;
                  if (last_q) begin
`ifdef MAP_LOOP_EN
                     addr_q  <= '0;
                     state_q <= FETCH;
`else
                     state_q <= DONE;
`endif
                     done_q  <= 1'b1;
                  end else begin
                     addr_q  <= addr_q + 1'b1;
                     state_q <= FETCH;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign col_valid  = valid_q;
   assign col_data   = data_q;
   assign col_count  = count_q;
   assign level_done = done_q;
   assign busy       = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_map_column_feeder.sv
// Randomized bench for map_column_feeder against a descriptor-walking reference model.
module tb_map_column_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        col_ready;
   logic        col_valid;
   logic [99:0] col_data;
   logic [15:0] col_count;
   logic        level_done;
   logic        busy;

   int          checks = 0;
   int          failures = 0;
   logic [23:0] bm [256];
   logic [99:0] exp_q [$];
   int          exp_first;

   map_column_feeder dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .col_ready  (col_ready),
      .col_valid  (col_valid),
      .col_data   (col_data),
      .col_count  (col_count),
      .level_done (level_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] mk(input int c, input int f, input int run, input bit last);
      return {1'b0, last, 8'(run), 7'(f), 7'(c)};
   endfunction

   function automatic logic [99:0] ref_col(input int c, input int f);
      logic [100:0] top;
      logic [99:0]  ones;
      ones = '1;
      if (c > 100) c = 100;
      if (f > 100) f = 100;
      top = (101'd1 << c) - 101'd1;
      return top[99:0] | ~(ones >> f);
   endfunction

   task automatic clear_map();
      for (int i = 0; i < 256; i++) bm[i] = '0;
   endtask

   task automatic load();
      for (int i = 0; i < 256; i++) dut.u_rom.mem[i] = bm[i];
   endtask

   // Walk descriptors from 0: each run emits run copies; zero runs cost two cycles.
   task automatic build_model();
      int  zeros;
      bit  seen;
      int  run;
      zeros = 0;
      seen  = 0;
      exp_q.delete();
      for (int a = 0; a < 256; a++) begin
         run = int'(bm[a][21:14]);
         if (run == 0 && !seen) zeros++;
         if (run > 0) seen = 1;
         for (int r = 0; r < run; r++) exp_q.push_back(ref_col(int'(bm[a][6:0]), int'(bm[a][13:7])));
         if (bm[a][22] || a == 255) break;
      end
      exp_first = 3 + 2 * zeros;
   endtask

   task automatic play(input string name, input int pct, input int hold0);
      int hs;
      int idx;
      int cyc;
      int h0;
      bit seen;
      bit done;
      hs = 0; idx = 0; cyc = 1; h0 = hold0; seen = 0; done = 0;
      build_model();
      load();
      col_ready = 0;
      start = 1;
      step();
      start = 0;
      chk({name, ":ld_clear"}, level_done, 0);
      while (cyc < 700 + 40 * exp_q.size()) begin
         chk({name, ":count"}, col_count, hs);
         if (!col_valid && level_done && hs == exp_q.size()) begin
            done = 1;
            break;
         end
         start = 0;
         if (col_valid) begin
            chk({name, ":busy"}, busy, 1);
            if (!seen) begin
               seen = 1;
               chk({name, ":first_valid_cycle"}, cyc, exp_first);
            end
            if (idx < exp_q.size()) chk({name, ":data"}, col_data, exp_q[idx]);
            else chk({name, ":extra_column"}, 1, 0);
            if (h0 > 0) begin
               col_ready = 0;
               h0--;
            end else begin
               col_ready = ($urandom_range(99) < pct);
            end
            // Start while busy must be ignored.
            start = ($urandom_range(9) == 0);
            if (col_ready) begin
               hs++;
               idx++;
            end
         end else begin
            col_ready = 1'($urandom_range(1));
         end
         step();
         cyc++;
      end
      start = 0;
      col_ready = 0;
      chk({name, ":finished_in_budget"}, done, 1);
      chk({name, ":columns"}, hs, exp_q.size());
      chk({name, ":level_done"}, level_done, 1);
      chk({name, ":busy_done"}, busy, 0);
      chk({name, ":valid_done"}, col_valid, 0);
   endtask

   task automatic reset_test();
      int hs;
      hs = 0;
      clear_map();
      bm[0] = mk(10, 30, 5, 1);
      load();
      col_ready = 1;
      start = 1;
      step();
      start = 0;
      for (int c = 0; c < 20 && hs < 2; c++) begin
         if (col_valid) hs++;
         step();
      end
      chk("rst:pre_count", col_count, 2);
      reset = 1;
      #1;
      chk("rst:valid", col_valid, 0);
      chk("rst:count", col_count, 0);
      chk("rst:data", col_data, 0);
      chk("rst:busy", busy, 0);
      step();
      reset = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("rst:no_output", col_valid, 0);
      end
      play("rst_resume", 100, 0);
   endtask

   task automatic loop_test();
      logic [99:0] cols_exp [4];
      int hs;
      int pulses;
      bit prev_last;
      hs = 0; pulses = 0; prev_last = 0;
      clear_map();
      bm[0] = mk(10, 0, 2, 0);
      bm[1] = mk(0, 10, 2, 1);
      load();
      cols_exp[0] = ref_col(10, 0);
      cols_exp[1] = cols_exp[0];
      cols_exp[2] = ref_col(0, 10);
      cols_exp[3] = cols_exp[2];
      col_ready = 1;
      start = 1;
      step();
      start = 0;
      for (int c = 0; c < 200 && hs < 12; c++) begin
         chk("loop:busy", busy, 1);
         chk("loop:count", col_count, hs);
         chk("loop:level_done", level_done, prev_last);
         if (level_done) pulses++;
         prev_last = 0;
         if (col_valid) begin
            chk("loop:data", col_data, cols_exp[hs % 4]);
            hs++;
            prev_last = (hs % 4 == 0);
         end
         step();
      end
      chk("loop:columns", hs, 12);
      chk("loop:level_done_end", level_done, prev_last);
      if (level_done) pulses++;
      chk("loop:pulses", pulses, 3);
      chk("loop:busy_end", busy, 1);
   endtask

   initial begin
      int n;
      reset = 1;
      start = 0;
      col_ready = 0;
      clear_map();
      step();
      step();
      chk("reset:valid", col_valid, 0);
      chk("reset:data", col_data, 0);
      chk("reset:count", col_count, 0);
      chk("reset:level_done", level_done, 0);
      chk("reset:busy", busy, 0);
      reset = 0;
      step();
      chk("idle:busy", busy, 0);
`ifdef MAP_LOOP_EN
      loop_test();
`else
      bm[0] = mk(20, 20, 3, 1);
      play("basic", 100, 0);
      play("stall", 100, 10);
      clear_map();
      bm[0] = mk(0, 0, 0, 0);
      bm[1] = mk(60, 60, 1, 1);
      play("zero_run_skip", 100, 0);
      reset_test();
      clear_map();
      bm[255] = mk(5, 0, 1, 0);
      play("addr255", 100, 0);
      for (int t = 0; t < 8; t++) begin
         clear_map();
         n = int'($urandom_range(6, 1));
         for (int i = 0; i < n; i++)
            bm[i] = mk(int'($urandom_range(127)), int'($urandom_range(127)),
                       int'($urandom_range(3)), (i == n - 1));
         play("random", int'($urandom_range(100, 30)), 0);
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
